mem_port_arbiter: RTL and testbench

Shares the single unified instruction/data memory port of the multicycle ARM core between two requesters. Port 0 is the core's memory interface (Adr/WriteData/MemWrite/ReadData). Port 1 is a secondary master, such as a program loader or debug DMA. The block issues one memory access per cycle with a same-cycle grant, tracks outstanding reads with an owner-tag pipeline, and routes read data back to the issuing port. Port 1 can hold the memory across a burst with a lock.

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/mem_port_arbiter_rd_tag_pipe.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 tb/tb_mem_port_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: port ids, owner FSM states, latency bound.
package mem_port_arbiter_pkg;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_AUX  = 1'b1
    } port_t;

    typedef enum logic {
        IDLE  = 1'b0,
        LOCK1 = 1'b1
    } own_state_t;

    localparam int MEM_LAT_MAX = 4;

endpackage

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: MEM_LAT-deep shift register of {valid, owner} for in-flight reads,
// synchronously cleared by an active-low reset.
module rd_tag_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  in_vld,
    input  port_t in_own,
    output logic  out_vld,
    output port_t out_own
);

    if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
        $error("rd_tag_pipe: MEM_LAT out of range");
    end

    logic [MEM_LAT-1:0] vld_pipe;
    port_t              own_pipe [MEM_LAT];

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_pipe <= '0;
            for (int i = 0; i < MEM_LAT; i++) own_pipe[i] <= PORT_CORE;
        end else begin
            vld_pipe[0] <= in_vld;
            own_pipe[0] <= in_own;
            for (int i = 1; i < MEM_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                own_pipe[i] <= own_pipe[i-1];
            end
        end
    end

    assign out_vld = vld_pipe[MEM_LAT-1];
    assign out_own = own_pipe[MEM_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the unified memory port: same-cycle grant, port 1 burst lock,
// read data routed back by owner tag. Define ARB_ROUND_ROBIN_EN for alternating tie-break.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_adr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic          p1_lock,
    input  logic [AW-1:0] p1_adr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          m_we,
    output logic [AW-1:0] m_adr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    own_state_t state, state_nxt;
    port_t      last_gnt, winner, fin_own;
    logic       lock_hold, tie_aux, any_gnt, fin_vld;

    always_comb begin
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        state_nxt = state;
        // The lock only holds while port 1 keeps both req and lock up; dropping
        // either falls straight through to normal arbitration this cycle.
        lock_hold = (state == LOCK1) && p1_req && p1_lock;
        tie_aux   = RR_EN && (last_gnt == PORT_CORE);

        if (reset) begin
            if (lock_hold) begin
                p1_gnt = 1'b1;
            end else if (p0_req && p1_req) begin
                p1_gnt = tie_aux;
                p0_gnt = !tie_aux;
            end else begin
                p0_gnt = p0_req;
                p1_gnt = p1_req;
            end
        end

        case (state)
            IDLE:    if (p1_gnt && p1_lock) state_nxt = LOCK1;
            LOCK1:   if (!p1_req || !p1_lock) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign any_gnt = p0_gnt | p1_gnt;
    assign winner  = p1_gnt ? PORT_AUX : PORT_CORE;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            last_gnt <= PORT_AUX;
        end else begin
            state <= state_nxt;
            if (any_gnt) last_gnt <= winner;
        end
    end

    // Idle bus parks on port 0's command; forced to zero while in reset.
    assign m_we    = p1_gnt ? p1_we : (p0_gnt & p0_we);
    assign m_adr   = !reset ? '0 : (p1_gnt ? p1_adr : p0_adr);
    assign m_wdata = !reset ? '0 : (p1_gnt ? p1_wdata : p0_wdata);

    rd_tag_pipe #(.MEM_LAT(MEM_LAT)) u_tags (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (any_gnt && !m_we),
        .in_own  (winner),
        .out_vld (fin_vld),
        .out_own (fin_own)
    );

    // Gating with reset suppresses a return that lands in the reset cycle itself.
    assign p0_rvalid = reset && fin_vld && (fin_own == PORT_CORE);
    assign p1_rvalid = reset && fin_vld && (fin_own == PORT_AUX);
    assign p0_rdata  = p0_rvalid ? m_rdata : '0;
    assign p1_rdata  = p1_rvalid ? m_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench: two arbiters (MEM_LAT 1 and 3) on shared stimulus, scoreboard of expected read
// returns checked by per-instance monitors; grants checked against a rule-level model.
module tb_mem_port_arbiter;

    localparam int NI = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b0;
    logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0, p1_lock = 1'b0;
    logic [31:0] p0_adr = '0, p0_wdata = '0, p1_adr = '0, p1_wdata = '0;

    wire         p0_gnt_w [NI], p1_gnt_w [NI], p0_rv_w [NI], p1_rv_w [NI], m_we_w [NI];
    wire  [31:0] p0_rd_w [NI], p1_rd_w [NI], m_adr_w [NI], m_wdata_w [NI], m_rdata_w [NI];

    typedef struct {
        int          due;
        logic        port;
        logic [31:0] data;
    } exp_t;

    exp_t        expq [NI][$];
    int          lat_of [NI] = '{1, 3};
    int          nchk = 0, npass = 0, cur = -1;

    // reference model state
    logic        m_locked = 1'b0, m_last = 1'b1;
    logic [31:0] ref_mem [logic [31:0]];
    logic        last_eg0, last_eg1;

    function automatic logic [31:0] mem_init(logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]} ^ 32'h3C5A9617;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", nm, cur, act, exp);
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] emem [logic [31:0]];
        logic [31:0] rpipe [LAT];

        mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) u_dut (
            .clk(clk), .reset(reset),
            .p0_req(p0_req), .p0_we(p0_we), .p0_adr(p0_adr), .p0_wdata(p0_wdata),
            .p0_gnt(p0_gnt_w[g]), .p0_rvalid(p0_rv_w[g]), .p0_rdata(p0_rd_w[g]),
            .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_adr(p1_adr),
            .p1_wdata(p1_wdata), .p1_gnt(p1_gnt_w[g]), .p1_rvalid(p1_rv_w[g]),
            .p1_rdata(p1_rd_w[g]), .m_we(m_we_w[g]), .m_adr(m_adr_w[g]),
            .m_wdata(m_wdata_w[g]), .m_rdata(m_rdata_w[g])
        );

        // memory: reads the bus every cycle, data appears LAT cycles later
        assign m_rdata_w[g] = rpipe[LAT-1];
        always @(posedge clk) begin
            rpipe[0] <= emem.exists(m_adr_w[g]) ? emem[m_adr_w[g]] : mem_init(m_adr_w[g]);
            for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
            if (m_we_w[g] === 1'b1) emem[m_adr_w[g]] = m_wdata_w[g];
        end

        always @(negedge clk) begin : mon
            logic        ev0, ev1;
            logic [31:0] ed;
            if (cur >= 0) begin
                ev0 = 1'b0; ev1 = 1'b0; ed = '0;
                if (expq[g].size() > 0 && expq[g][0].due == cur) begin
                    ev0 = !expq[g][0].port;
                    ev1 = expq[g][0].port;
                    ed  = expq[g][0].data;
                    void'(expq[g].pop_front());
                end
                chk($sformatf("L%0d p0_rvalid", LAT), 32'(p0_rv_w[g]), 32'(ev0));
                chk($sformatf("L%0d p1_rvalid", LAT), 32'(p1_rv_w[g]), 32'(ev1));
                chk($sformatf("L%0d p0_rdata", LAT), p0_rd_w[g], ev0 ? ed : 32'h0);
                chk($sformatf("L%0d p1_rdata", LAT), p1_rd_w[g], ev1 ? ed : 32'h0);
            end
        end
    end

    task automatic step(input logic r, input logic q0, input logic w0,
                        input logic [31:0] a0, input logic [31:0] d0,
                        input logic q1, input logic w1, input logic l1,
                        input logic [31:0] a1, input logic [31:0] d1);
        logic        eg0, eg1, wp;
        logic [31:0] ea, ed;
        @(posedge clk);
        #1;
        cur++;
        reset = r; p0_req = q0; p0_we = w0; p0_adr = a0; p0_wdata = d0;
        p1_req = q1; p1_we = w1; p1_lock = l1; p1_adr = a1; p1_wdata = d1;
        eg0 = 1'b0; eg1 = 1'b0;
        if (!r) begin
            m_locked = 1'b0;
            m_last   = 1'b1;
            for (int g = 0; g < NI; g++) expq[g].delete();
        end else begin
            if (m_locked && q1 && l1) eg1 = 1'b1;
            else if (q0 && q1) begin
`ifdef ARB_ROUND_ROBIN_EN
                eg1 = (m_last == 1'b0);
`else
                eg1 = 1'b0;
`endif
                eg0 = !eg1;
            end else begin
                eg0 = q0;
                eg1 = q1;
            end
            m_locked = eg1 && l1;
            if (eg0 || eg1) m_last = eg1;
        end
        wp = eg1 ? w1 : w0;
        ea = eg1 ? a1 : a0;
        ed = eg1 ? d1 : d0;
        if (eg0 || eg1) begin
            if (wp) ref_mem[ea] = ed;
            else for (int g = 0; g < NI; g++)
                expq[g].push_back('{due: cur + lat_of[g], port: eg1,
                                    data: ref_mem.exists(ea) ? ref_mem[ea] : mem_init(ea)});
        end
        last_eg0 = eg0;
        last_eg1 = eg1;
        #1;
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("L%0d p0_gnt", lat_of[g]), 32'(p0_gnt_w[g]), 32'(eg0));
            chk($sformatf("L%0d p1_gnt", lat_of[g]), 32'(p1_gnt_w[g]), 32'(eg1));
            chk($sformatf("L%0d m_we", lat_of[g]), 32'(m_we_w[g]), 32'((eg0 || eg1) && wp));
            if (r) begin
                chk($sformatf("L%0d m_adr", lat_of[g]), m_adr_w[g], ea);
                chk($sformatf("L%0d m_wdata", lat_of[g]), m_wdata_w[g], (eg0 || eg1) ? ed : d0);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    logic [3:0]  tie_exp;
    logic        q0, w0, q1, w1, l1, r, pend0, pend1;
    logic [31:0] a0, d0, a1, d1;

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        tie_exp = 4'b0101;
`else
        tie_exp = 4'b1111;
`endif
        repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // tie right after reset: port 0 first
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 1'b0, 32'hC, 32'h0);
            chk("tie p0_gnt", 32'(p0_gnt_w[0]), 32'(tie_exp[i]));
        end
        idle(4);

        // single port 0 read of 0x100
        step(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(4);

        // port 0 write
        step(1'b1, 1'b1, 1'b1, 32'h40, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(4);

        // port 1 locked burst, port 0 locked out until lock drops
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h80, 32'hA0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 1'b1, 32'h84 + 32'(i*4), 32'hA1 + 32'(i));
            chk("locked p0_gnt", 32'(p0_gnt_w[0]), 32'h0);
        end
        step(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 1'b0, 32'h90, 32'hA4);
        chk("release p0_gnt", 32'(p0_gnt_w[0]), 32'h1);
        idle(4);

        // interleaved reads
        step(1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h84, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(4);

        // reset right after a read grant drops the return
        step(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 1'b0, 32'hC, 32'h0);
        chk("post-reset tie p0_gnt", 32'(p0_gnt_w[0]), 32'h1);
        idle(4);

        // random traffic honouring the hold-until-grant handshake
        pend0 = 1'b0; pend1 = 1'b0;
        q0 = 0; w0 = 0; a0 = 0; d0 = 0; q1 = 0; w1 = 0; l1 = 0; a1 = 0; d1 = 0;
        for (int n = 0; n < 500; n++) begin
            r = ($urandom_range(0, 63) != 0);
            if (!pend0 || $urandom_range(0, 7) == 0) begin
                q0 = ($urandom_range(0, 2) != 0);
                w0 = ($urandom_range(0, 2) == 0);
                a0 = 32'($urandom_range(0, 15)) << 2;
                d0 = $urandom;
            end
            if (!pend1 || $urandom_range(0, 7) == 0) begin
                q1 = ($urandom_range(0, 2) != 0);
                w1 = ($urandom_range(0, 2) == 0);
                l1 = m_locked ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                a1 = 32'($urandom_range(0, 15)) << 2;
                d1 = $urandom;
            end
            step(r, q0, w0, a0, d0, q1, w1, l1, a1, d1);
            pend0 = q0 && !last_eg0;
            pend1 = q1 && !last_eg1;
        end
        idle(6);
        for (int g = 0; g < NI; g++) chk("queue drained", 32'(expq[g].size()), 32'h0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
